// File: rtl/change_dispenser_if.sv
// Handshake and status bundle for the change dispenser.
// The design drives the slave side; the stimulus side drives master.
interface change_dispenser_if;
    logic       start;
    logic [7:0] change_in;
    logic       abort;
    logic       out_money_fifty;
    logic       out_money_twenty;
    logic       out_money_ten;
    logic       out_money_five;
    logic       out_money_one;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [3:0] coin_count;

    modport master (
        output start, change_in, abort,
        input  out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one,
        input  busy, done, remaining, coin_count
    );

    modport slave (
        input  start, change_in, abort,
        output out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one,
        output busy, done, remaining, coin_count
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: splits an amount into 50/20/10/5/1 pulses,
// one pulse per coin, separated by GAP_CYCLES idle cycles.
module change_dispenser #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    change_dispenser_if.slave   bus
);
    localparam int unsigned AMT_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned DEN_W = 5;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

    state_t             r_state, w_next_state;
    logic [AMT_W-1:0]   r_remaining, w_remaining;
    logic [AMT_W-1:0]   r_denom, w_denom, w_pick;
    logic [CNT_W-1:0]   r_coin_count, w_coin_count;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
    logic [DEN_W-1:0]   r_pulse, w_pulse;   // {fifty, twenty, ten, five, one}
    logic               r_busy, w_busy;
    logic               r_done, w_done;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next_state = (bus.change_in == '0) ? S_DONE : S_SELECT;
            S_SELECT: w_next_state = bus.abort ? S_IDLE : S_PULSE;
            S_PULSE:  w_next_state = bus.abort ? S_IDLE : S_GAP;
            S_GAP: begin
                if (bus.abort)               w_next_state = S_IDLE;
                else if (r_gap_cnt == '0)    w_next_state = (r_remaining == '0) ? S_DONE : S_SELECT;
            end
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Next values for every registered output and datapath register
    always_comb begin
        w_remaining  = r_remaining;
        w_coin_count = r_coin_count;
        w_denom      = r_denom;
        w_gap_cnt    = r_gap_cnt;
        w_pulse      = '0;

        if      (r_remaining >= AMT_W'(50)) w_pick = AMT_W'(50);
        else if (r_remaining >= AMT_W'(20)) w_pick = AMT_W'(20);
        else if (r_remaining >= AMT_W'(10)) w_pick = AMT_W'(10);
        else if (r_remaining >= AMT_W'(5))  w_pick = AMT_W'(5);
        else if (r_remaining != '0)         w_pick = AMT_W'(1);
        else                                w_pick = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_remaining  = bus.change_in;
                    w_coin_count = '0;
                end
            end
            S_SELECT: w_denom = w_pick;
            // The pulse's bookkeeping completes even if abort is seen this cycle
            S_PULSE: begin
                if (r_denom <= r_remaining) w_remaining = r_remaining - r_denom;
                else                        w_remaining = '0;
                if (r_coin_count != '1) w_coin_count = r_coin_count + CNT_W'(1);
                w_gap_cnt = GAP_W'(GAP_CYCLES - 1);
            end
            S_GAP: if (r_gap_cnt != '0) w_gap_cnt = r_gap_cnt - GAP_W'(1);
            default: ;
        endcase

        if (w_next_state == S_PULSE) begin
            case (w_denom)
                AMT_W'(50): w_pulse = 5'b10000;
                AMT_W'(20): w_pulse = 5'b01000;
                AMT_W'(10): w_pulse = 5'b00100;
                AMT_W'(5):  w_pulse = 5'b00010;
                AMT_W'(1):  w_pulse = 5'b00001;
                default:    w_pulse = '0;
            endcase
        end

        w_busy = (w_next_state != S_IDLE);
        w_done = (w_next_state == S_DONE);
    end

    // Output and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_remaining  <= '0;
            r_coin_count <= '0;
            r_denom      <= '0;
            r_gap_cnt    <= '0;
            r_pulse      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_remaining  <= w_remaining;
            r_coin_count <= w_coin_count;
            r_denom      <= w_denom;
            r_gap_cnt    <= w_gap_cnt;
            r_pulse      <= w_pulse;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    assign bus.out_money_fifty  = r_pulse[4];
    assign bus.out_money_twenty = r_pulse[3];
    assign bus.out_money_ten    = r_pulse[2];
    assign bus.out_money_five   = r_pulse[1];
    assign bus.out_money_one    = r_pulse[0];
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.remaining        = r_remaining;
    assign bus.coin_count       = r_coin_count;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with GAP_CYCLES=4; expected pulse
// cycles and codes are hand-computed (cycle 0 = edge that samples start).
module tb_change_dispenser;
    localparam logic [4:0] P50 = 5'b10000;
    localparam logic [4:0] P20 = 5'b01000;
    localparam logic [4:0] P10 = 5'b00100;
    localparam logic [4:0] P5  = 5'b00010;
    localparam logic [4:0] P1  = 5'b00001;
    localparam int NLOG = 128;

    logic sys_clk;
    logic sys_rst_n;
    change_dispenser_if bus ();

    change_dispenser #(.GAP_CYCLES(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] log_p [NLOG];
    logic       log_d [NLOG];
    logic       log_b [NLOG];
    logic [4:0] exp_p [NLOG];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] pulses_now();
        return {bus.out_money_fifty, bus.out_money_twenty, bus.out_money_ten,
                bus.out_money_five, bus.out_money_one};
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < NLOG; i++) exp_p[i] = '0;
    endtask

    // Caller is at a negedge; start is presented for cycle 0 and outputs logged for cycles 1..ncyc
    task automatic run(input logic [7:0] amt, input int ncyc, input int abort_cyc,
                       input int start2_cyc, input int rst_cyc);
        bus.start     = 1'b1;
        bus.change_in = amt;
        @(posedge sys_clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge sys_clk);
            log_p[c] = pulses_now();
            log_d[c] = bus.done;
            log_b[c] = bus.busy;
            bus.abort = (c == abort_cyc);
            bus.start = (c == start2_cyc);
            if (c == start2_cyc) bus.change_in = 8'd10;
            if (c == rst_cyc) begin
                sys_rst_n = 1'b0;
                #1;
                check("async reset pulses", 32'(pulses_now()), 32'd0);
                check("async reset busy", 32'(bus.busy), 32'd0);
                check("async reset remaining", 32'(bus.remaining), 32'd0);
            end else begin
                sys_rst_n = 1'b1;
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic verify(input string tag, input int ncyc, input int done_cyc, input int busy_end);
        for (int c = 1; c <= ncyc; c++) begin
            check($sformatf("%s pulse c%0d", tag, c), 32'(log_p[c]), 32'(exp_p[c]));
            check($sformatf("%s done c%0d", tag, c), 32'(log_d[c]), 32'(c == done_cyc));
            check($sformatf("%s busy c%0d", tag, c), 32'(log_b[c]), 32'(c <= busy_end));
        end
    endtask

    int         cyc249 [11] = '{2, 8, 14, 20, 26, 32, 38, 44, 50, 56, 62};
    logic [4:0] cod249 [11] = '{P50, P50, P50, P50, P20, P20, P5, P1, P1, P1, P1};

    initial begin
        sys_rst_n     = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.change_in = 8'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset pulses", 32'(pulses_now()), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset remaining", 32'(bus.remaining), 32'd0);
        check("reset coin_count", 32'(bus.coin_count), 32'd0);

        // 76 accepted on the first edge after reset release
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_exp();
        exp_p[2] = P50; exp_p[8] = P20; exp_p[14] = P5; exp_p[20] = P1;
        run(8'd76, 27, -1, -1, -1);
        verify("amt76", 27, 25, 25);
        check("amt76 remaining", 32'(bus.remaining), 32'd0);
        check("amt76 coin_count", 32'(bus.coin_count), 32'd4);

        // zero amount
        clear_exp();
        run(8'd0, 4, -1, -1, -1);
        verify("amt0", 4, 1, 1);
        check("amt0 coin_count", 32'(bus.coin_count), 32'd0);
        check("amt0 remaining", 32'(bus.remaining), 32'd0);

        // 249 with abort raised alongside start: start wins
        clear_exp();
        for (int k = 0; k < 11; k++) exp_p[cyc249[k]] = cod249[k];
        bus.abort = 1'b1;
        run(8'd249, 69, -1, -1, -1);
        verify("amt249", 69, 67, 67);
        check("amt249 remaining", 32'(bus.remaining), 32'd0);
        check("amt249 coin_count", 32'(bus.coin_count), 32'd11);

        // 255 aborted in cycle 9
        clear_exp();
        exp_p[2] = P50; exp_p[8] = P50;
        run(8'd255, 20, 9, -1, -1);
        verify("abort255", 20, -1, 9);
        check("abort255 remaining", 32'(bus.remaining), 32'd155);
        check("abort255 coin_count", 32'(bus.coin_count), 32'd2);

        // start while busy ignored
        clear_exp();
        exp_p[2] = P50; exp_p[8] = P20; exp_p[14] = P5; exp_p[20] = P1;
        run(8'd76, 27, -1, 5, -1);
        verify("busy76", 27, 25, 25);
        check("busy76 remaining", 32'(bus.remaining), 32'd0);
        check("busy76 coin_count", 32'(bus.coin_count), 32'd4);

        clear_exp();
        exp_p[2] = P10;
        run(8'd10, 9, -1, -1, -1);
        verify("amt10", 9, 7, 7);
        check("amt10 remaining", 32'(bus.remaining), 32'd0);
        check("amt10 coin_count", 32'(bus.coin_count), 32'd1);

        // reset pulse during the first GAP of a 76 transaction
        clear_exp();
        exp_p[2] = P50;
        run(8'd76, 35, -1, -1, 4);
        verify("rst76", 35, -1, 4);
        check("rst76 remaining", 32'(bus.remaining), 32'd0);
        check("rst76 coin_count", 32'(bus.coin_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: idle cycles between consecutive coin pulses; legal range 1..15.
REQ-002 SHALL have port sys_clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: one-cycle request to dispense change_in; sampled only in IDLE.
REQ-005 SHALL have port change_in, input, 8: change amount in yuan (0..255), sampled with start.
REQ-006 SHALL have port abort, input, 1: terminates a transaction in progress.
REQ-007 SHALL have ports out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one, each output, 1: one-cycle dispense pulse per coin or note.
REQ-008 SHALL have port busy, output, 1: high in every non-IDLE state.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port remaining, output, 8: amount still to dispense.
REQ-011 SHALL have port coin_count, output, 4: pulses issued in the current or last transaction.

Function
REQ-012 SHALL use states IDLE, SELECT, PULSE, GAP, DONE.
REQ-013 SHALL register all outputs; no combinational path from any input to any output.
REQ-014 IDLE: if start=1, SHALL latch change_in into remaining and clear coin_count to 0. Next state is DONE if change_in=0, else SELECT.
REQ-015 SELECT (1 cycle): SHALL choose the largest denomination in {50,20,10,5,1} that is <= remaining, giving greedy decomposition. Next state PULSE.
REQ-016 PULSE (1 cycle): SHALL drive exactly the chosen out_money_* high for this cycle only. remaining SHALL decrease by the denomination and coin_count SHALL increment by 1, both visible from the next cycle. Next state GAP.
REQ-017 GAP: SHALL last exactly GAP_CYCLES cycles with all out_money_* low. Next state DONE if remaining=0, else SELECT.
REQ-018 DONE (1 cycle): SHALL drive done=1 with busy=1. Next state IDLE.
REQ-019 Timing: take cycle 0 as the IDLE cycle in which start is sampled. Pulse k (1-based) SHALL be high in cycle 2+(k-1)*(GAP_CYCLES+2). For N pulses, done SHALL be high in cycle N*(GAP_CYCLES+2)+1.
REQ-020 Zero amount: done SHALL be high in cycle 1 with no pulses issued.
REQ-021 At most one out_money_* SHALL be high in any cycle.
REQ-022 start while busy=1 SHALL be ignored; remaining and coin_count are unaffected.
REQ-023 abort=1 in any state other than IDLE or DONE SHALL force IDLE on the next edge.
REQ-024 An aborted transaction SHALL not raise done.
REQ-025 An abort sampled in a PULSE cycle SHALL still complete that pulse's remaining and coin_count update.
REQ-026 Once the FSM is back in IDLE after an abort, remaining SHALL hold the undispensed amount.
REQ-027 abort and start in the same IDLE cycle: start SHALL win.
REQ-028 remaining SHALL never underflow.
REQ-029 coin_count SHALL saturate at 15; the greedy maximum is 11, so saturation is never reached for legal inputs.
REQ-030 remaining and coin_count SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-031 While sys_rst_n=0, asynchronously: state=IDLE, all out_money_*=0, busy=0, done=0, remaining=0, coin_count=0.
REQ-032 Reset deasserted mid-transaction SHALL resume from IDLE with no pulse or done produced.
REQ-033 First start SHALL be accepted on the first rising edge after sys_rst_n rises.

Verification (GAP_CYCLES=4)
REQ-034 start with change_in=76 -> pulses fifty@2, twenty@8, five@14, one@20; done@25; coin_count=4; remaining=0.
REQ-035 start with change_in=0 -> done@1, no pulses, coin_count=0, busy high in cycle 1 only.
REQ-036 start with change_in=249 -> 11 pulses (4x fifty, 2x twenty, 1x five, 4x one, in that order); done@67.
REQ-037 start with change_in=255, abort in cycle 9 -> pulses @2 and @8 only; no done; busy low from cycle 10; remaining=155; coin_count=2.
REQ-038 Second start (change_in=10) during a 76 transaction -> ignored; original sequence completes unchanged; next start in IDLE dispenses one ten.
REQ-039 sys_rst_n low for 1 cycle during GAP of a 76 transaction -> all outputs 0 immediately; no further pulses; remaining=0.
